seg_scan_display: RTL

Parametrised multiplexed 7-segment scan driver; successor to the fixed 3-digit display driver. Drives DIGITS common-anode/cathode digits from a packed nibble bus, with hex or BCD glyph mode, leading-zero blanking, per-digit decimal points and a ghosting guard interval between digits. Captures new values into a shadow register and swaps them in only at frame boundaries, so a displayed frame never mixes old and new data. Sits between the ranging/measurement logic and the board display pins.

---
 rtl/seg_scan_display.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver.
// Scans DIGITS digits from a packed nibble bus, one digit per dwell period.
// Each dwell starts with a guard interval (all digits dark) to suppress ghosting,
// then shows the selected digit. New data is held in a shadow register and only
// moves to the display register at the frame boundary (index wrap), so one frame
// never mixes old and new values. All pin-facing outputs are registered.
module seg_scan_display #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int DIGIT_HZ       = 1000,
    parameter int DIGITS         = 4,
    parameter int BLANK_CYCLES   = 50,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_SEL = 1'b1
) (
    input  logic                  CLK_50M,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  data_valid,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg_duan,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     seg_sel,
    output logic                  frame_done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int DWELL = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] LAST_CNT   = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

    // Inactive pin levels, used for reset and for every guard cycle.
    localparam logic [DIGITS-1:0] SEL_OFF = ACTIVE_LOW_SEL ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Each dwell begins in GUARD unless there are no guard cycles at all,
    // in which case the dwell is entirely SHOW.
    localparam scan_state_t FIRST_STATE = (BLANK_CYCLES > 0) ? ST_GUARD : ST_SHOW;

    // ------------------------------------------------------------------
    // Glyph table (active-high a..g, bit0 = a)
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        // In BCD mode anything above 9 is out of range and shown as a dash.
        if (!hex && (nib > 4'd9)) begin
            g = 7'h40;
        end
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t         state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       index_reg, index_next;
    logic                frame_wrap;

    logic [4*DIGITS-1:0] shadow_data_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic                pending_reg;
    logic [4*DIGITS-1:0] disp_data_reg;
    logic [DIGITS-1:0]   disp_dp_reg;

    logic [DIGITS-1:0]   sel_on_next;
    logic [6:0]          seg_on_next;
    logic                dp_on_next;

    logic [DIGITS-1:0]   seg_sel_reg;
    logic [6:0]          seg_duan_reg;
    logic                seg_dp_reg;
    logic                frame_done_reg;

    // Per-digit active-high segment patterns after leading-zero blanking.
    logic [6:0]          digit_seg [DIGITS];

    // ------------------------------------------------------------------
    // Per-digit glyph lookup and leading-zero blanking
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                // The rightmost digit is always shown so zero reads as "0".
                assign digit_seg[gi] = glyph(disp_data_reg[3:0], hex_mode);
            end else begin : g_upper
                logic all_zero_above;
                // Blank when this nibble and every more-significant one is zero.
                assign all_zero_above = ~|disp_data_reg[4*DIGITS-1:4*gi];
                assign digit_seg[gi]  = (lz_blank && all_zero_above)
                                        ? 7'h00
                                        : glyph(disp_data_reg[4*gi+3:4*gi], hex_mode);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan FSM: state, dwell counter and digit index registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (!RST) begin
            state_reg <= FIRST_STATE;
            cnt_reg   <= '0;
            index_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            index_reg <= index_next;
        end
    end

    // Next-state logic plus the active-high pin pattern for the current cycle
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CW'(1);
        index_next  = index_reg;
        frame_wrap  = 1'b0;
        sel_on_next = '0;
        seg_on_next = '0;
        dp_on_next  = 1'b0;

        if (cnt_reg == LAST_CNT) begin
            // Last SHOW count of this dwell: advance to the next digit.
            cnt_next   = '0;
            state_next = FIRST_STATE;
            if (index_reg == LAST_IDX) begin
                index_next = '0;
                frame_wrap = 1'b1;
            end else begin
                index_next = index_reg + IW'(1);
            end
        end else if ((state_reg == ST_GUARD) && (cnt_reg == GUARD_LAST)) begin
            state_next = ST_SHOW;
        end

        if (state_reg == ST_SHOW) begin
            sel_on_next[index_reg] = 1'b1;
            seg_on_next            = digit_seg[index_reg];
            // Decimal point is independent of blanking.
            dp_on_next             = disp_dp_reg[index_reg];
        end
    end

    // ------------------------------------------------------------------
    // Capture path: shadow register, pending flag, display register
    // ------------------------------------------------------------------
    // Strobes land in the shadow; the shadow is promoted only at the frame wrap.
    // A strobe on the wrap cycle itself bypasses the shadow so it shows at once.
    always_ff @(posedge CLK_50M) begin
        if (!RST) begin
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            pending_reg     <= 1'b0;
            disp_data_reg   <= '0;
            disp_dp_reg     <= '0;
        end else if (data_valid) begin
            shadow_data_reg <= data;
            shadow_dp_reg   <= dp;
            if (frame_wrap) begin
                disp_data_reg <= data;
                disp_dp_reg   <= dp;
                pending_reg   <= 1'b0;
            end else begin
                pending_reg   <= 1'b1;
            end
        end else if (frame_wrap && pending_reg) begin
            disp_data_reg <= shadow_data_reg;
            disp_dp_reg   <= shadow_dp_reg;
            pending_reg   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers with pin polarity applied
    // ------------------------------------------------------------------
    // Registered pins, one cycle behind the scan state.
    always_ff @(posedge CLK_50M) begin
        if (!RST) begin
            seg_sel_reg    <= SEL_OFF;
            seg_duan_reg   <= SEG_OFF;
            seg_dp_reg     <= DP_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            seg_sel_reg    <= ACTIVE_LOW_SEL ? ~sel_on_next : sel_on_next;
            seg_duan_reg   <= ACTIVE_LOW_SEG ? ~seg_on_next : seg_on_next;
            seg_dp_reg     <= ACTIVE_LOW_SEG ? ~dp_on_next  : dp_on_next;
            frame_done_reg <= frame_wrap;
        end
    end

    assign seg_sel    = seg_sel_reg;
    assign seg_duan   = seg_duan_reg;
    assign seg_dp     = seg_dp_reg;
    assign frame_done = frame_done_reg;

endmodule
